roce_stack_xlat_arbiter: RTL and testbench
==========================================

Name: roce_stack_xlat_arbiter

Overview:
- Shares one address-translation lookup port between the RoCE read request handler and the write request handler, which previously needed two ports.
- Round-robin arbitrates translation requests (vaddr, qpn) onto the shared port.
- Records the issue order in a tag FIFO and routes each in-order response back to the requester that issued it.
- Sits between the two request handlers and the translation table, in the axis_aclk_i domain.

Parameters:
MAX_OUTSTANDING, 8, tag FIFO depth: maximum accepted requests whose responses have not yet been delivered (power of 2, ≥2)
CNT_W, $clog2(MAX_OUTSTANDING)+1, width of outstanding_o

Ports:
axis_aclk_i  in  1  clock
areset_i  in  1  synchronous active-high reset
rd_req_valid_i  in  1  read-side translation request valid
rd_req_ready_o  out  1  read-side request accepted
rd_req_vaddr_i  in  64  read-side virtual address
rd_req_qpn_i  in  16  read-side QPN
rd_resp_valid_o  out  1  read-side response valid
rd_resp_ready_i  in  1  read-side response ready
rd_resp_data_o  out  dma_req_t  read-side translated DMA request
wr_req_valid_i  in  1  write-side request valid
wr_req_ready_o  out  1  write-side request accepted
wr_req_vaddr_i  in  64  write-side virtual address
wr_req_qpn_i  in  16  write-side QPN
wr_resp_valid_o  out  1  write-side response valid
wr_resp_ready_i  in  1  write-side response ready
wr_resp_data_o  out  dma_req_t  write-side translated DMA request
xlat_req_valid_o  out  1  shared lookup request valid (registered)
xlat_req_ready_i  in  1  lookup port accepts request
xlat_req_vaddr_o  out  64  registered vaddr
xlat_req_qpn_o  out  16  registered qpn
xlat_resp_valid_i  in  1  lookup response valid
xlat_resp_ready_o  out  1  lookup response consumed
xlat_resp_data_i  in  dma_req_t  lookup response
outstanding_o  out  CNT_W  current tag FIFO occupancy
err_unexp_resp_o  out  1  sticky: response arrived with empty tag FIFO

Behaviour:
- Reset (areset_i=1 at a clock edge):
  - Outputs: xlat_req_valid_o=0, xlat_req_vaddr_o=0, xlat_req_qpn_o=0, outstanding_o=0, err_unexp_resp_o=0.
  - Tag FIFO emptied; round-robin pointer set to favour read.
  - Anything in flight is discarded, with no replay.
  - While areset_i=1, all ready outputs are 0.
- Load condition: can_load = (!xlat_req_valid_o || xlat_req_ready_i) && !fifo_full.
  - fifo_full is the registered occupancy == MAX_OUTSTANDING.
  - A same-cycle pop does not unblock a push.
- Grant:
  - Only one valid: that side is granted.
  - Both valid: the side not granted on the last accepted transfer wins.
  - Pointer updates only on an accepted transfer.
- Ready outputs: rd_req_ready_o = can_load && grant_rd; wr_req_ready_o = can_load && grant_wr. At most one is high per cycle.
- On acceptance:
  - vaddr/qpn load into the output register.
  - xlat_req_valid_o=1 the next cycle (1-cycle latency).
  - The tag (0=rd, 1=wr) is pushed into the FIFO in the same cycle.
- Output register handshake:
  - Register holds stable while xlat_req_valid_o && !xlat_req_ready_i.
  - It clears when accepted with no new load.
  - Back-to-back loads sustain 1 request/cycle.
- Response routing:
  - Purely combinational, zero latency, driven by the FIFO head tag.
  - Head=0: rd_resp_valid_o = xlat_resp_valid_i; rd_resp_data_o = xlat_resp_data_i; xlat_resp_ready_o = rd_resp_ready_i.
  - Head=1: same mapping on the write side.
  - The non-selected side's valid is 0. Both data outputs always carry xlat_resp_data_i.
  - The FIFO pops on xlat_resp_valid_i && xlat_resp_ready_o.
- Unexpected response (FIFO empty):
  - xlat_resp_ready_o=1, so the response is dropped.
  - Neither resp_valid is asserted.
  - err_unexp_resp_o is set and held until reset.
- Simultaneous push and pop: occupancy unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o is the registered occupancy, updated the cycle after each push/pop.
- A response may arrive the cycle after the request handshake; the tag is already present.

Test Plan:
- Reset, then a single rd request (vaddr=0x1000, qpn=0x11) with xlat_req_ready_i=1 -> xlat_req_valid_o high 1 cycle later with 0x1000/0x11; outstanding_o=1; response routed to rd_resp_valid_o only; outstanding_o returns to 0.
- rd and wr valid every cycle, xlat_req_ready_i=1 -> grants alternate rd, wr, rd, wr…; xlat_req_valid_o continuous. 4 responses return routed rd, wr, rd, wr.
- xlat_req_ready_i=0 for 5 cycles with a request pending -> output register holds its values stable; a second request is accepted only after the register drains.
- MAX_OUTSTANDING=8, no responses, 8 accepted requests -> both req_ready=0 and outstanding_o=8. One response popped -> a new request is accepted the following cycle, not the same cycle.
- Response with head=wr and wr_resp_ready_i=0 for 3 cycles -> xlat_resp_ready_o=0 and no pop; rd_resp_valid_o stays 0.
- xlat_resp_valid_i with empty FIFO -> consumed, no resp_valid; err_unexp_resp_o=1 until areset_i. Reset asserted with 3 outstanding -> outstanding_o=0 the next cycle.

Source files
------------

// File: rtl/roce_stack_xlat_arbiter.sv
// Purpose: shares one translation lookup port between the RoCE read and write request handlers; a tag FIFO routes in-order responses back to their issuer.
// Latency: 1 cycle from request acceptance to xlat_req_valid_o; responses are routed combinationally with zero latency.
// Backpressure: requests stall while the output register is held or the tag FIFO is full; a response stalls only on the ready of its owning requester.

package roce_stack_xlat_arbiter_pkg;
  // Translated DMA request returned by the translation table.
  typedef struct packed {
    logic [63:0] paddr;
    logic [31:0] len;
    logic [15:0] qpn;
  } dma_req_t;
endpackage

module roce_stack_xlat_arbiter
  import roce_stack_xlat_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             axis_aclk_i,
  input  logic             areset_i,
  // read-side request / response
  input  logic             rd_req_valid_i,
  output logic             rd_req_ready_o,
  input  logic [63:0]      rd_req_vaddr_i,
  input  logic [15:0]      rd_req_qpn_i,
  output logic             rd_resp_valid_o,
  input  logic             rd_resp_ready_i,
  output dma_req_t         rd_resp_data_o,
  // write-side request / response
  input  logic             wr_req_valid_i,
  output logic             wr_req_ready_o,
  input  logic [63:0]      wr_req_vaddr_i,
  input  logic [15:0]      wr_req_qpn_i,
  output logic             wr_resp_valid_o,
  input  logic             wr_resp_ready_i,
  output dma_req_t         wr_resp_data_o,
  // shared translation lookup port
  output logic             xlat_req_valid_o,
  input  logic             xlat_req_ready_i,
  output logic [63:0]      xlat_req_vaddr_o,
  output logic [15:0]      xlat_req_qpn_o,
  input  logic             xlat_resp_valid_i,
  output logic             xlat_resp_ready_o,
  input  dma_req_t         xlat_resp_data_i,
  // status
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_unexp_resp_o
);

  localparam int               PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  // registered state
  logic                       xlat_vld_q, xlat_vld_d;
  logic [63:0]                xlat_vaddr_q, xlat_vaddr_d;
  logic [15:0]                xlat_qpn_q, xlat_qpn_d;
  logic                       last_wr_q, last_wr_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           occ_q, occ_d;
  logic                       err_q, err_d;

  // combinational control
  logic fifo_full;
  logic fifo_empty;
  logic head_tag;
  logic can_load;
  logic grant_rd;
  logic grant_wr;
  logic accept;
  logic pop;

  // Round-robin grant and load qualification; full is judged on registered occupancy only.
  always_comb begin
    fifo_full  = (occ_q == FULL_CNT);
    fifo_empty = (occ_q == '0);
    can_load   = !areset_i && (!xlat_vld_q || xlat_req_ready_i) && !fifo_full;
    grant_rd   = rd_req_valid_i && (!wr_req_valid_i || last_wr_q);
    grant_wr   = wr_req_valid_i && !grant_rd;
    accept     = can_load && (grant_rd || grant_wr);
    rd_req_ready_o = can_load && grant_rd;
    wr_req_ready_o = can_load && grant_wr;
    last_wr_d  = accept ? grant_wr : last_wr_q;
  end

  // Output request register: load on accept, hold under backpressure, clear once drained.
  always_comb begin
    xlat_vld_d   = xlat_vld_q;
    xlat_vaddr_d = xlat_vaddr_q;
    xlat_qpn_d   = xlat_qpn_q;
    if (accept) begin
      xlat_vld_d   = 1'b1;
      xlat_vaddr_d = grant_wr ? wr_req_vaddr_i : rd_req_vaddr_i;
      xlat_qpn_d   = grant_wr ? wr_req_qpn_i   : rd_req_qpn_i;
    end else if (xlat_req_ready_i) begin
      xlat_vld_d = 1'b0;
    end
  end

  // Response routing by FIFO head tag; with no tag outstanding the response is swallowed.
  always_comb begin
    head_tag          = tag_q[rd_ptr_q];
    rd_resp_valid_o   = 1'b0;
    wr_resp_valid_o   = 1'b0;
    xlat_resp_ready_o = 1'b0;
    if (fifo_empty) begin
      xlat_resp_ready_o = !areset_i;
    end else if (head_tag) begin
      wr_resp_valid_o   = xlat_resp_valid_i;
      xlat_resp_ready_o = wr_resp_ready_i && !areset_i;
    end else begin
      rd_resp_valid_o   = xlat_resp_valid_i;
      xlat_resp_ready_o = rd_resp_ready_i && !areset_i;
    end
    pop   = xlat_resp_valid_i && xlat_resp_ready_o && !fifo_empty;
    err_d = err_q || (xlat_resp_valid_i && xlat_resp_ready_o && fifo_empty);
  end

  // Tag FIFO bookkeeping: push the granted side on accept, pop on delivered response.
  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (accept) begin
      tag_d[wr_ptr_q] = grant_wr;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers with synchronous reset; the read side is favoured after reset.
  always_ff @(posedge axis_aclk_i) begin
    if (areset_i) begin
      xlat_vld_q   <= 1'b0;
      xlat_vaddr_q <= '0;
      xlat_qpn_q   <= '0;
      last_wr_q    <= 1'b1;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      xlat_vld_q   <= xlat_vld_d;
      xlat_vaddr_q <= xlat_vaddr_d;
      xlat_qpn_q   <= xlat_qpn_d;
      last_wr_q    <= last_wr_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      err_q        <= err_d;
    end
  end

  assign xlat_req_valid_o = xlat_vld_q;
  assign xlat_req_vaddr_o = xlat_vaddr_q;
  assign xlat_req_qpn_o   = xlat_qpn_q;
  assign rd_resp_data_o   = xlat_resp_data_i;
  assign wr_resp_data_o   = xlat_resp_data_i;
  assign outstanding_o    = occ_q;
  assign err_unexp_resp_o = err_q;

endmodule

// File: tb/tb_roce_stack_xlat_arbiter.sv
// Purpose: scoreboard bench for roce_stack_xlat_arbiter with directed request/response sequences.
// Latency: expects request on the shared port 1 cycle after acceptance, responses routed in the same cycle.
// Backpressure: exercises lookup-port stall, tag FIFO full and requester response stall.

module tb_roce_stack_xlat_arbiter;
  import roce_stack_xlat_arbiter_pkg::*;

  typedef struct packed {
    logic [63:0] vaddr;
    logic [15:0] qpn;
  } exp_req_t;

  typedef struct packed {
    logic     side;
    dma_req_t d;
  } exp_resp_t;

  logic        clk = 1'b0;
  logic        areset;
  logic        rd_req_valid_i, rd_req_ready_o;
  logic [63:0] rd_req_vaddr_i;
  logic [15:0] rd_req_qpn_i;
  logic        rd_resp_valid_o, rd_resp_ready_i;
  dma_req_t    rd_resp_data_o;
  logic        wr_req_valid_i, wr_req_ready_o;
  logic [63:0] wr_req_vaddr_i;
  logic [15:0] wr_req_qpn_i;
  logic        wr_resp_valid_o, wr_resp_ready_i;
  dma_req_t    wr_resp_data_o;
  logic        xlat_req_valid_o, xlat_req_ready_i;
  logic [63:0] xlat_req_vaddr_o;
  logic [15:0] xlat_req_qpn_o;
  logic        xlat_resp_valid_i, xlat_resp_ready_o;
  dma_req_t    xlat_resp_data_i;
  logic [3:0]  outstanding_o;
  logic        err_unexp_resp_o;

  int n_chk  = 0;
  int n_pass = 0;

  exp_req_t  exp_req[$];
  exp_resp_t exp_resp[$];

  always #5 clk = ~clk;

  roce_stack_xlat_arbiter #(.MAX_OUTSTANDING(8)) dut (
    .axis_aclk_i       (clk),
    .areset_i          (areset),
    .rd_req_valid_i    (rd_req_valid_i),
    .rd_req_ready_o    (rd_req_ready_o),
    .rd_req_vaddr_i    (rd_req_vaddr_i),
    .rd_req_qpn_i      (rd_req_qpn_i),
    .rd_resp_valid_o   (rd_resp_valid_o),
    .rd_resp_ready_i   (rd_resp_ready_i),
    .rd_resp_data_o    (rd_resp_data_o),
    .wr_req_valid_i    (wr_req_valid_i),
    .wr_req_ready_o    (wr_req_ready_o),
    .wr_req_vaddr_i    (wr_req_vaddr_i),
    .wr_req_qpn_i      (wr_req_qpn_i),
    .wr_resp_valid_o   (wr_resp_valid_o),
    .wr_resp_ready_i   (wr_resp_ready_i),
    .wr_resp_data_o    (wr_resp_data_o),
    .xlat_req_valid_o  (xlat_req_valid_o),
    .xlat_req_ready_i  (xlat_req_ready_i),
    .xlat_req_vaddr_o  (xlat_req_vaddr_o),
    .xlat_req_qpn_o    (xlat_req_qpn_o),
    .xlat_resp_valid_i (xlat_resp_valid_i),
    .xlat_resp_ready_o (xlat_resp_ready_o),
    .xlat_resp_data_i  (xlat_resp_data_i),
    .outstanding_o     (outstanding_o),
    .err_unexp_resp_o  (err_unexp_resp_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic dma_req_t mk(input int i);
    dma_req_t r;
    r.paddr = 64'hA000_0000_0000_0000 | 64'(i);
    r.len   = 32'(i * 64 + 1);
    r.qpn   = 16'(i + 256);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [63:0] va, input logic [15:0] q);
    exp_req_t e;
    e.vaddr = va;
    e.qpn   = q;
    exp_req.push_back(e);
  endtask

  task automatic push_resp(input logic side, input int i);
    exp_resp_t e;
    e.side = side;
    e.d    = mk(i);
    exp_resp.push_back(e);
  endtask

  // One response with both requesters ready; routing is checked in the cycle it is presented.
  task automatic send_resp(input logic side, input int i);
    xlat_resp_valid_i = 1'b1;
    xlat_resp_data_i  = mk(i);
    push_resp(side, i);
    #1;
    check("resp_ready", xlat_resp_ready_o, 1'b1);
    check("resp_rd_vld", rd_resp_valid_o, !side);
    check("resp_wr_vld", wr_resp_valid_o, side);
    tick();
    xlat_resp_valid_i = 1'b0;
  endtask

  // Monitor: compares every completed handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (!areset) begin
      if (xlat_req_valid_o && xlat_req_ready_i) begin
        check("xlat_req_expected", exp_req.size() != 0, 1'b1);
        if (exp_req.size() != 0) begin
          exp_req_t e;
          e = exp_req.pop_front();
          check("xlat_req_vaddr", xlat_req_vaddr_o, e.vaddr);
          check("xlat_req_qpn", xlat_req_qpn_o, e.qpn);
        end
      end
      if (rd_resp_valid_o || wr_resp_valid_o)
        check("resp_onehot", rd_resp_valid_o & wr_resp_valid_o, 1'b0);
      if ((rd_resp_valid_o && rd_resp_ready_i) || (wr_resp_valid_o && wr_resp_ready_i)) begin
        check("resp_expected", exp_resp.size() != 0, 1'b1);
        if (exp_resp.size() != 0) begin
          exp_resp_t e;
          e = exp_resp.pop_front();
          check("resp_side", wr_resp_valid_o, e.side);
          check("resp_data", wr_resp_valid_o ? wr_resp_data_o : rd_resp_data_o, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    rd_req_valid_i = 0; rd_req_vaddr_i = '0; rd_req_qpn_i = '0; rd_resp_ready_i = 1'b1;
    wr_req_valid_i = 0; wr_req_vaddr_i = '0; wr_req_qpn_i = '0; wr_resp_ready_i = 1'b1;
    xlat_req_ready_i = 1'b1; xlat_resp_valid_i = 0; xlat_resp_data_i = '0;
    tick(); tick();

    // readies are held low during reset even with requests pending
    rd_req_valid_i = 1'b1; wr_req_valid_i = 1'b1;
    #1;
    check("rst_rd_rdy", rd_req_ready_o, 1'b0);
    check("rst_wr_rdy", wr_req_ready_o, 1'b0);
    check("rst_resp_rdy", xlat_resp_ready_o, 1'b0);
    rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0;
    tick();
    check("rst_xv", xlat_req_valid_o, 1'b0);
    check("rst_vaddr", xlat_req_vaddr_o, 64'h0);
    check("rst_qpn", xlat_req_qpn_o, 16'h0);
    check("rst_occ", outstanding_o, 4'd0);
    check("rst_err", err_unexp_resp_o, 1'b0);
    areset = 1'b0;
    tick();

    // T1: single read request and its response
    rd_req_valid_i = 1'b1; rd_req_vaddr_i = 64'h1000; rd_req_qpn_i = 16'h11;
    #1;
    check("t1_rd_rdy", rd_req_ready_o, 1'b1);
    push_req(64'h1000, 16'h11);
    tick();
    rd_req_valid_i = 1'b0;
    check("t1_xv", xlat_req_valid_o, 1'b1);
    check("t1_occ1", outstanding_o, 4'd1);
    tick();
    check("t1_xv_clr", xlat_req_valid_o, 1'b0);
    send_resp(1'b0, 1);
    check("t1_occ0", outstanding_o, 4'd0);

    // T2: both sides valid every cycle, grants alternate starting with read after reset
    areset = 1'b1; tick(); areset = 1'b0; tick();
    rd_req_valid_i = 1'b1; wr_req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_req_vaddr_i = 64'h2000 + 64'(i); rd_req_qpn_i = 16'h20 + 16'(i);
      wr_req_vaddr_i = 64'h3000 + 64'(i); wr_req_qpn_i = 16'h30 + 16'(i);
      #1;
      check("t2_rd_rdy", rd_req_ready_o, (i % 2) == 0);
      check("t2_wr_rdy", wr_req_ready_o, (i % 2) == 1);
      if (i > 0) check("t2_xv_cont", xlat_req_valid_o, 1'b1);
      if (i % 2 == 0) push_req(64'h2000 + 64'(i), 16'h20 + 16'(i));
      else            push_req(64'h3000 + 64'(i), 16'h30 + 16'(i));
      tick();
    end
    rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0;
    check("t2_occ4", outstanding_o, 4'd4);
    for (int i = 0; i < 4; i++) send_resp(1'(i % 2), 10 + i);
    check("t2_occ0", outstanding_o, 4'd0);

    // T3: lookup port stalled, output register must hold
    xlat_req_ready_i = 1'b0;
    rd_req_valid_i = 1'b1; rd_req_vaddr_i = 64'h4000; rd_req_qpn_i = 16'h44;
    #1;
    check("t3_rd_rdy", rd_req_ready_o, 1'b1);
    push_req(64'h4000, 16'h44);
    tick();
    rd_req_vaddr_i = 64'h5000; rd_req_qpn_i = 16'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_xv", xlat_req_valid_o, 1'b1);
      check("t3_hold_vaddr", xlat_req_vaddr_o, 64'h4000);
      check("t3_hold_qpn", xlat_req_qpn_o, 16'h44);
      check("t3_blocked", rd_req_ready_o, 1'b0);
      tick();
    end
    xlat_req_ready_i = 1'b1;
    #1;
    check("t3_rd_rdy2", rd_req_ready_o, 1'b1);
    push_req(64'h5000, 16'h55);
    tick();
    rd_req_valid_i = 1'b0;
    tick();
    check("t3_xv_clr", xlat_req_valid_o, 1'b0);
    check("t3_occ2", outstanding_o, 4'd2);
    send_resp(1'b0, 20);
    send_resp(1'b0, 21);

    // T4: fill the tag FIFO; a pop frees a slot only on the following cycle
    rd_req_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_req_vaddr_i = 64'h6000 + 64'(i); rd_req_qpn_i = 16'h60 + 16'(i);
      #1;
      check("t4_fill_rdy", rd_req_ready_o, 1'b1);
      push_req(64'h6000 + 64'(i), 16'h60 + 16'(i));
      tick();
    end
    rd_req_vaddr_i = 64'h7000; rd_req_qpn_i = 16'h70;
    wr_req_valid_i = 1'b1; wr_req_vaddr_i = 64'h7100; wr_req_qpn_i = 16'h71;
    #1;
    check("t4_full_rd_rdy", rd_req_ready_o, 1'b0);
    check("t4_full_wr_rdy", wr_req_ready_o, 1'b0);
    check("t4_occ8", outstanding_o, 4'd8);
    xlat_resp_valid_i = 1'b1; xlat_resp_data_i = mk(30);
    push_resp(1'b0, 30);
    #1;
    check("t4_pop_rdy", xlat_resp_ready_o, 1'b1);
    check("t4_samecyc_rd", rd_req_ready_o, 1'b0);
    check("t4_samecyc_wr", wr_req_ready_o, 1'b0);
    tick();
    xlat_resp_valid_i = 1'b0;
    #1;
    check("t4_next_wr_rdy", wr_req_ready_o, 1'b1);
    check("t4_next_rd_rdy", rd_req_ready_o, 1'b0);
    push_req(64'h7100, 16'h71);
    tick();
    rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0;
    check("t4_occ8b", outstanding_o, 4'd8);
    for (int i = 0; i < 7; i++) send_resp(1'b0, 31 + i);

    // T5: write response held off by its requester
    check("t5_occ1", outstanding_o, 4'd1);
    wr_resp_ready_i = 1'b0;
    xlat_resp_valid_i = 1'b1; xlat_resp_data_i = mk(40);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_stall_rdy", xlat_resp_ready_o, 1'b0);
      check("t5_rd_vld", rd_resp_valid_o, 1'b0);
      check("t5_wr_vld", wr_resp_valid_o, 1'b1);
      tick();
    end
    check("t5_nopop", outstanding_o, 4'd1);
    wr_resp_ready_i = 1'b1;
    push_resp(1'b1, 40);
    tick();
    xlat_resp_valid_i = 1'b0;
    check("t5_occ0", outstanding_o, 4'd0);

    // T6: unexpected response sets sticky error; reset clears it and outstanding
    xlat_resp_valid_i = 1'b1; xlat_resp_data_i = mk(50);
    #1;
    check("t6_unexp_rdy", xlat_resp_ready_o, 1'b1);
    check("t6_unexp_rd", rd_resp_valid_o, 1'b0);
    check("t6_unexp_wr", wr_resp_valid_o, 1'b0);
    check("t6_err_pre", err_unexp_resp_o, 1'b0);
    tick();
    xlat_resp_valid_i = 1'b0;
    check("t6_err_set", err_unexp_resp_o, 1'b1);
    tick(); tick();
    check("t6_err_sticky", err_unexp_resp_o, 1'b1);
    check("t6_occ0", outstanding_o, 4'd0);
    rd_req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_req_vaddr_i = 64'h8000 + 64'(i); rd_req_qpn_i = 16'h80 + 16'(i);
      #1;
      check("t6_rd_rdy", rd_req_ready_o, 1'b1);
      push_req(64'h8000 + 64'(i), 16'h80 + 16'(i));
      tick();
    end
    rd_req_valid_i = 1'b0;
    check("t6_occ3", outstanding_o, 4'd3);
    tick();
    check("t6_occ3b", outstanding_o, 4'd3);
    areset = 1'b1;
    tick();
    check("t6_rst_occ", outstanding_o, 4'd0);
    check("t6_rst_err", err_unexp_resp_o, 1'b0);
    check("t6_rst_xv", xlat_req_valid_o, 1'b0);
    areset = 1'b0;
    tick();
    check("t6_post_occ", outstanding_o, 4'd0);

    check("end_req_q_empty", 32'(exp_req.size()), 32'd0);
    check("end_resp_q_empty", 32'(exp_resp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
